// File: rtl/cla_pkg.sv
// Shared constants and parameter legality check for the carry-lookahead adder.
// Latency: none (package only).
// Backpressure: none (package only).
//
// Contents:
//   CLA_GROUP      bits per first-level lookahead group
//   cla_width_ok   true when a WIDTH value can be built from whole groups
package cla_pkg;

   localparam int CLA_GROUP = 4;

   // Legal widths are whole groups, one to eight groups (4..32 bits).
   function automatic bit cla_width_ok(input int width);
      return (width % CLA_GROUP == 0) && (width >= CLA_GROUP) && (width <= 32);
   endfunction

endpackage

// File: rtl/carry_look_ahead_adder_if.sv
// Operand/result bundle for the registered carry-lookahead adder.
// Latency: n/a (signal bundle only).
// Backpressure: none; the adder accepts every in_valid cycle.
//
// Signals:
//   a, b, cin, in_valid          driven by the master (operand source)
//   s, cout, grp_p, grp_g,
//   out_valid                    driven by the slave (the adder)
interface carry_look_ahead_adder_if #(
   parameter int WIDTH = 4
);
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             cin;
   logic             in_valid;
   logic [WIDTH-1:0] s;
   logic             cout;
   logic             grp_p;
   logic             grp_g;
   logic             out_valid;

   modport master (
      output a, b, cin, in_valid,
      input  s, cout, grp_p, grp_g, out_valid
   );

   modport slave (
      input  a, b, cin, in_valid,
      output s, cout, grp_p, grp_g, out_valid
   );
endinterface

// File: rtl/cla_group4.sv
// 4-bit carry-lookahead group: sum bits plus group propagate/generate.
// Latency: purely combinational.
// Backpressure: none.
//
// Ports:
//   a_i, b_i   4-bit operand slices
//   c_i        carry into bit 0 of the group
//   sum_o      4-bit sum slice
//   grp_p_o    group propagate (all four bits propagate)
//   grp_g_o    group generate (group produces a carry on its own)
module cla_group4
   import cla_pkg::*;
(
   input  logic [CLA_GROUP-1:0] a_i,
   input  logic [CLA_GROUP-1:0] b_i,
   input  logic                 c_i,
   output logic [CLA_GROUP-1:0] sum_o,
   output logic                 grp_p_o,
   output logic                 grp_g_o
);

   logic [CLA_GROUP-1:0] p;
   logic [CLA_GROUP-1:0] g;
   logic                 c1;
   logic                 c2;
   logic                 c3;

   assign p = a_i ^ b_i;
   assign g = a_i & b_i;

   // Each carry is a flat sum of products from c_i, never from the previous
   // carry. The group's own carry-out is produced by the next lookahead level.
   assign c1 = g[0] | (p[0] & c_i);
   assign c2 = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c_i);
   assign c3 = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
             | (p[2] & p[1] & p[0] & c_i);

   assign sum_o = p ^ {c3, c2, c1, c_i};

   assign grp_p_o = &p;
   assign grp_g_o = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
                  | (p[3] & p[2] & p[1] & g[0]);

endmodule

// File: rtl/carry_look_ahead_adder.sv
// Registered WIDTH-bit carry-lookahead adder: {cout, s} = a + b + cin.
// Latency: 1 cycle, one addition per cycle.
// Backpressure: none; outputs load on in_valid and hold otherwise.
//
// Ports:
//   clk, rst   rising-edge clock, synchronous active-high reset
//   bus        slave side of carry_look_ahead_adder_if (operands in,
//              registered sum/carry/group P,G and out_valid out)
module carry_look_ahead_adder
   import cla_pkg::*;
#(
   parameter int WIDTH = 4
) (
   input  logic                     clk,
   input  logic                     rst,
   carry_look_ahead_adder_if.slave  bus
);

   localparam int NG = WIDTH / CLA_GROUP;   // first-level groups
   localparam int NS = (NG + 3) / 4;        // super-groups of up to 4 groups

   if (!cla_width_ok(WIDTH)) begin : g_width_chk
      $error("carry_look_ahead_adder: WIDTH=%0d must be a multiple of 4 in 4..32", WIDTH);
   end

   logic [NG-1:0]    gp;      // group propagate
   logic [NG-1:0]    gg;      // group generate
   logic [NG-1:0]    gc;      // carry into each group
   logic [NS-1:0]    sp;      // super-group propagate
   logic [NS-1:0]    sg;      // super-group generate
   logic [NS-1:0]    sc;      // carry into each super-group
   logic             top_p;
   logic             top_g;

   logic [WIDTH-1:0] s_d;
   logic             cout_d;

   logic [WIDTH-1:0] s_q;
   logic             cout_q;
   logic             grp_p_q;
   logic             grp_g_q;
   logic             vld_q;

   for (genvar k = 0; k < NG; k++) begin : g_grp
      cla_group4 u_grp (
         .a_i     (bus.a[k*CLA_GROUP +: CLA_GROUP]),
         .b_i     (bus.b[k*CLA_GROUP +: CLA_GROUP]),
         .c_i     (gc[k]),
         .sum_o   (s_d[k*CLA_GROUP +: CLA_GROUP]),
         .grp_p_o (gp[k]),
         .grp_g_o (gg[k])
      );
   end

   // Lookahead over group P/G. Every carry is formed as a sum of products
   // walking down from the nearest term, so the loops unroll into flat
   // AND-OR trees: one level up to 16 bits, a super-group level for 32 bits.
   always_comb begin : lookahead
      logic acc_g;
      logic acc_p;
      int   base;
      acc_g = 1'b0;
      acc_p = 1'b1;
      base  = 0;
      sg    = '0;
      sp    = '1;
      sc    = '0;
      gc    = '0;
      top_g = 1'b0;
      top_p = 1'b1;

      // Super-group P/G, built from the top group downwards.
      for (int k = NG - 1; k >= 0; k--) begin
         sg[k/4] = sg[k/4] | (sp[k/4] & gg[k]);
         sp[k/4] = sp[k/4] & gp[k];
      end

      // Carry into each super-group, seeded directly from cin.
      sc[0] = bus.cin;
      for (int m = 1; m < NS; m++) begin
         acc_g = 1'b0;
         acc_p = 1'b1;
         for (int l = m - 1; l >= 0; l--) begin
            acc_g = acc_g | (acc_p & sg[l]);
            acc_p = acc_p & sp[l];
         end
         sc[m] = acc_g | (acc_p & bus.cin);
      end

      // Carry into each group from its super-group carry-in.
      for (int k = 0; k < NG; k++) begin
         base  = (k / 4) * 4;
         acc_g = 1'b0;
         acc_p = 1'b1;
         for (int j = k - 1; j >= base; j--) begin
            acc_g = acc_g | (acc_p & gg[j]);
            acc_p = acc_p & gp[j];
         end
         gc[k] = acc_g | (acc_p & sc[k/4]);
      end

      // Whole-word P/G; the word carry-out needs no ripple either.
      for (int l = NS - 1; l >= 0; l--) begin
         top_g = top_g | (top_p & sg[l]);
         top_p = top_p & sp[l];
      end
   end

   assign cout_d = top_g | (top_p & bus.cin);

   always_ff @(posedge clk) begin
      if (rst) begin
         s_q     <= '0;
         cout_q  <= 1'b0;
         grp_p_q <= 1'b0;
         grp_g_q <= 1'b0;
         vld_q   <= 1'b0;
      end else begin
         vld_q <= bus.in_valid;
         if (bus.in_valid) begin
            s_q     <= s_d;
            cout_q  <= cout_d;
            grp_p_q <= top_p;
            grp_g_q <= top_g;
         end
      end
   end

   assign bus.s         = s_q;
   assign bus.cout      = cout_q;
   assign bus.grp_p     = grp_p_q;
   assign bus.grp_g     = grp_g_q;
   assign bus.out_valid = vld_q;

endmodule

// File: tb/tb_carry_look_ahead_adder.sv
// Self-checking bench for carry_look_ahead_adder at WIDTH 4 and 16.
// Latency: expects results one cycle after the sampling edge.
// Backpressure: none; a scoreboard queue pairs each driven cycle with its result.
module tb_carry_look_ahead_adder;

   typedef struct packed {
      logic [31:0] s;
      logic        cout;
      logic        p;
      logic        g;
      logic        vld;
   } exp_t;

   logic clk;
   logic rst4;
   logic rst16;
   int   checks;
   int   failures;

   exp_t q4[$];
   exp_t q16[$];
   exp_t hold4;
   exp_t hold16;

   carry_look_ahead_adder_if #(.WIDTH(4))  if4  ();
   carry_look_ahead_adder_if #(.WIDTH(16)) if16 ();

   carry_look_ahead_adder #(.WIDTH(4)) dut4 (
      .clk (clk),
      .rst (rst4),
      .bus (if4)
   );

   carry_look_ahead_adder #(.WIDTH(16)) dut16 (
      .clk (clk),
      .rst (rst16),
      .bus (if16)
   );

   always #5 clk = ~clk;

   // Reference: plain integer addition, masked to the adder width.
   function automatic exp_t model(input int w, input logic [31:0] a,
                                  input logic [31:0] b, input logic cin);
      logic [32:0] t;
      logic [32:0] t0;
      logic [31:0] mask;
      exp_t        e;
      mask   = (w == 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
      t      = {1'b0, a & mask} + {1'b0, b & mask} + {32'd0, cin};
      t0     = {1'b0, a & mask} + {1'b0, b & mask};
      e.s    = t[31:0] & mask;
      e.cout = t[w];
      e.p    = &((a ^ b) | ~mask);
      e.g    = t0[w];
      e.vld  = 1'b1;
      return e;
   endfunction

   task automatic chk(input string tag, input logic [32:0] obs, input logic [32:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         failures++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   // Drive one cycle on the selected DUT, then compare its output after the edge.
   task automatic step(input int w, input logic [31:0] a, input logic [31:0] b,
                       input logic cin, input logic vld, input logic rs,
                       input string tag);
      exp_t e;
      exp_t got;
      got = '0;
      if (w == 4) begin
         if4.a = a[3:0]; if4.b = b[3:0]; if4.cin = cin; if4.in_valid = vld; rst4 = rs;
         if (rs) hold4 = '0;
         else if (vld) hold4 = model(4, a, b, cin);
         e = hold4;
         e.vld = vld & ~rs;
         q4.push_back(e);
      end else begin
         if16.a = a[15:0]; if16.b = b[15:0]; if16.cin = cin; if16.in_valid = vld; rst16 = rs;
         if (rs) hold16 = '0;
         else if (vld) hold16 = model(16, a, b, cin);
         e = hold16;
         e.vld = vld & ~rs;
         q16.push_back(e);
      end

      @(posedge clk);
      #1;

      if (w == 4) begin
         got.s = {28'd0, if4.s}; got.cout = if4.cout; got.p = if4.grp_p;
         got.g = if4.grp_g;      got.vld  = if4.out_valid;
         e = q4.pop_front();
      end else begin
         got.s = {16'd0, if16.s}; got.cout = if16.cout; got.p = if16.grp_p;
         got.g = if16.grp_g;      got.vld  = if16.out_valid;
         e = q16.pop_front();
      end
      chk($sformatf("%s.out_valid", tag), {32'd0, got.vld}, {32'd0, e.vld});
      chk($sformatf("%s.total", tag), {got.cout, got.s}, {e.cout, e.s});
      chk($sformatf("%s.grp_p", tag), {32'd0, got.p}, {32'd0, e.p});
      chk($sformatf("%s.grp_g", tag), {32'd0, got.g}, {32'd0, e.g});
   endtask

   initial begin
      logic [31:0] ra;
      logic [31:0] rb;
      logic        rc;
      logic        rv;
      clk      = 1'b0;
      rst4     = 1'b1;
      rst16    = 1'b1;
      checks   = 0;
      failures = 0;
      hold4    = '0;
      hold16   = '0;
      if4.a  = '0; if4.b  = '0; if4.cin  = 1'b0; if4.in_valid  = 1'b0;
      if16.a = '0; if16.b = '0; if16.cin = 1'b0; if16.in_valid = 1'b0;

      // Reset state on both widths.
      step(16, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1, "rst16");
      step(4,  32'h0, 32'h0, 1'b0, 1'b0, 1'b1, "rst4");

      // WIDTH = 4 directed sequence, back-to-back valid cycles.
      step(4, 32'h1, 32'h0, 1'b0, 1'b1, 1'b0, "add_1_0");
      step(4, 32'h2, 32'h4, 1'b1, 1'b1, 1'b0, "add_2_4_c");
      step(4, 32'h5, 32'h3, 1'b1, 1'b1, 1'b0, "add_5_3_c");
      step(4, 32'hB, 32'h6, 1'b0, 1'b1, 1'b0, "add_B_6");
      step(4, 32'hF, 32'h0, 1'b1, 1'b1, 1'b0, "add_F_0_c");
      step(4, 32'hF, 32'hF, 1'b1, 1'b1, 1'b0, "add_F_F_c");

      // Idle cycles with changing operands: result must hold.
      step(4, 32'h3, 32'h9, 1'b0, 1'b0, 1'b0, "hold_a");
      step(4, 32'hA, 32'h5, 1'b1, 1'b0, 1'b0, "hold_b");

      // Reset wins over a valid input; then recovery.
      step(4, 32'h9, 32'h9, 1'b1, 1'b1, 1'b1, "rst_vld");
      step(4, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, "post_rst");
      step(4, 32'h7, 32'h8, 1'b0, 1'b1, 1'b0, "add_7_8");
      step(4, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, "idle4");

      // WIDTH = 16: full carry propagation, then random vectors.
      step(16, 32'hFFFF, 32'h0001, 1'b0, 1'b1, 1'b0, "w16_ffff_1");
      step(16, 32'h8000, 32'h8000, 1'b1, 1'b1, 1'b0, "w16_msb");
      for (int i = 0; i < 10000; i++) begin
         ra = $urandom;
         rb = $urandom;
         rc = 1'($urandom_range(0, 1));
         rv = ($urandom_range(0, 7) != 0);
         step(16, {16'd0, ra[15:0]}, {16'd0, rb[15:0]}, rc, rv, 1'b0, "w16_rnd");
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
